load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and access classification.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    // Anything that is not a byte or halfword code is handled as a full word.
    function automatic logic is_subword(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU) || (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane alignment: extracts/extends a load lane and merges a store lane into a memory word.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];

        load_data  = word;
        merge_data = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                load_data  = {{24{byte_lane[7] & (funct3 == F3_B)}}, byte_lane};
                merge_data = word;
                case (addr_lo)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            F3_H, F3_HU: begin
                load_data  = {{16{half_lane[15] & (funct3 == F3_H)}}, half_lane};
                merge_data = word;
                if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
                else            merge_data[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-only RAM; sub-word stores use read-modify-write.
// Latency: load and word store 2 cycles, sub-word store 3 cycles; LSU_MISALIGN_TRAP_EN adds err traps.
// Backpressure: req_ready only in IDLE; requests presented while busy are ignored, not queued.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [N-1:0] req_addr,
    input  logic [31:0]  req_wdata,
    output logic         done,
    output logic [31:0]  rdata,
    output logic         err,
    output logic [N-1:0] mem_addr,
    output logic [31:0]  mem_wd,
    output logic         mem_we,
    input  logic [31:0]  mem_rd
);

    state_t       state;
    logic         we_q;
    logic [2:0]   f3_q;
    logic [N-1:0] addr_q;
    logic [31:0]  wdata_q;
    logic [31:0]  merge_q;
    logic [31:0]  load_data;
    logic [31:0]  merge_data;
    logic         req_bad;
    logic         acc_bad;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad = is_illegal(req_funct3, req_addr[1:0]);
    assign acc_bad = is_illegal(f3_q, addr_q[1:0]);
`else
    assign req_bad = 1'b0;
    assign acc_bad = 1'b0;
`endif

    assign req_ready = (state == S_IDLE);
    assign mem_addr  = {addr_q[N-1:2], 2'b00};
    assign mem_wd    = (state == S_WRITE) ? merge_q : wdata_q;

    lsu_lane_align u_align (
        .word       (mem_rd),
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            done    <= 1'b0;
            rdata   <= 32'h0;
            err     <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= S_ACCESS;
                        // Word stores write during ACCESS, so the strobe is raised at accept.
                        if (req_we && !is_subword(req_funct3) && !req_bad)
                            mem_we <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (acc_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else if (!we_q) begin
                        rdata <= load_data;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end else if (!is_subword(f3_q)) begin
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        merge_q <= merge_data;
                        mem_we  <= 1'b1;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    done  <= 1'b1;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM model, reference memory/rdata model, directed and random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Word RAM: combinational read, write on clk; a side port lets the bench preload it.
    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_dat = 32'h0;
    assign mem_rd = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pre_we)      mem[pre_idx] <= pre_dat;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    end

    int we_cnt = 0;
    int idle_viol = 0;
    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;
    always @(negedge clk) if (!rst && req_ready && mem_we) idle_viol <= idle_viol + 1;

    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          pulses;
        logic [31:0] memw;
    } res_t;

    function automatic logic model_bad(input logic [2:0] f3, input logic [7:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return a[1:0] != 2'b00;
            default:    return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Reference: what memory and rdata look like after the request, from the size/sign rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, output res_t e);
        int idx, sz, sh;
        logic [31:0] w, v, mask;
        idx = int'(a) / 4;
        w   = ref_mem[idx];
        sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sh  = (sz == 1) ? (int'(a) % 4) * 8 : (sz == 2) ? ((int'(a) / 2) % 2) * 16 : 0;
        e.err = model_bad(f3, a);
        e.lat = 2;
        e.pulses = 0;
        if (!e.err) begin
            if (!we) begin
                v = w >> sh;
                if (sz == 1) begin
                    v = v & 32'hFF;
                    if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
                end else if (sz == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                end
                ref_rdata = v;
            end else begin
                e.pulses = 1;
                if (sz == 4) begin
                    w = wd;
                end else begin
                    e.lat = 3;
                    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
                    w = (w & ~(mask << sh)) | ((wd & mask) << sh);
                end
                ref_mem[idx] = w;
            end
        end
        e.rdata = ref_rdata;
        e.memw  = ref_mem[idx];
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                           input logic [31:0] wd, output res_t o);
        int w0;
        w0 = we_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        o.lat = 99;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin
                o.lat = k;
                break;
            end
            @(posedge clk);
        end
        o.err    = err;
        o.rdata  = rdata;
        o.pulses = we_cnt - w0;
        o.memw   = mem[a[7:2]];
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pre_we  = 1'b1;
        pre_idx = idx[5:0];
        pre_dat = v;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp += 4;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        if ({done, err, mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset done/err/mem_we: got %b want 000", {done, err, mem_we}); end
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset rdata: got %h want 00000000", rdata); end
        if (mem_wd !== 32'h0 || mem_addr !== 8'h0) begin n_fail++; $display("FAIL reset mem_wd/mem_addr: got %h/%h want 0/0", mem_wd, mem_addr); end
        rst = 1'b0;
        ref_rdata = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_loads;
        logic [7:0]  ta [5] = '{8'h11, 8'h11, 8'h12, 8'h12, 8'h10};
        logic [2:0]  tf [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] tv [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
        res_t e, o;
        preload(4, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            model(1'b0, tf[i], ta[i], 32'h0, e);
            run_req(1'b0, tf[i], ta[i], 32'h0, o);
            n_cmp += 4;
            if (o.lat !== 2) begin n_fail++; $display("FAIL load[%0d] latency: got %0d want 2", i, o.lat); end
            if (o.rdata !== tv[i]) begin n_fail++; $display("FAIL load[%0d] rdata: got %h want %h", i, o.rdata, tv[i]); end
            if (o.err !== e.err) begin n_fail++; $display("FAIL load[%0d] err: got %b want %b", i, o.err, e.err); end
            if (o.pulses !== 0) begin n_fail++; $display("FAIL load[%0d] mem_we pulses: got %0d want 0", i, o.pulses); end
        end
    endtask

    task automatic test_store_byte;
        res_t e, o;
        preload(8, 32'h11223344);
        model(1'b1, 3'd0, 8'h22, 32'hDEADBEEF, e);
        run_req(1'b1, 3'd0, 8'h22, 32'hDEADBEEF, o);
        n_cmp += 4;
        if (o.lat !== 3) begin n_fail++; $display("FAIL sb latency: got %0d want 3", o.lat); end
        if (o.pulses !== 1) begin n_fail++; $display("FAIL sb mem_we pulses: got %0d want 1", o.pulses); end
        if (o.memw !== 32'h11EF3344) begin n_fail++; $display("FAIL sb mem: got %h want 11EF3344", o.memw); end
        if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL sb rdata kept: got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_back_to_back;
        res_t e1, o1, e2, o2;
        preload(8, 32'h11223344);
        model(1'b1, 3'd1, 8'h20, 32'h0000CAFE, e1);
        run_req(1'b1, 3'd1, 8'h20, 32'h0000CAFE, o1);
        n_cmp += 3;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready in done cycle: got %b want 1", req_ready); end
        if (o1.lat !== e1.lat) begin n_fail++; $display("FAIL b2b sh latency: got %0d want %0d", o1.lat, e1.lat); end
        if (o1.memw !== 32'h1122CAFE) begin n_fail++; $display("FAIL b2b sh mem: got %h want 1122CAFE", o1.memw); end
        model(1'b1, 3'd2, 8'h24, 32'h01020304, e2);
        run_req(1'b1, 3'd2, 8'h24, 32'h01020304, o2);
        n_cmp += 4;
        if (o2.lat !== 2) begin n_fail++; $display("FAIL b2b sw latency: got %0d want 2", o2.lat); end
        if (o2.pulses !== 1) begin n_fail++; $display("FAIL b2b sw pulses: got %0d want 1", o2.pulses); end
        if (o2.memw !== 32'h01020304) begin n_fail++; $display("FAIL b2b sw mem: got %h want 01020304", o2.memw); end
        if (mem[8] !== 32'h1122CAFE) begin n_fail++; $display("FAIL b2b sh mem after sw: got %h want 1122CAFE", mem[8]); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b done pulse width: got %b want 0", done); end
    endtask

    task automatic test_reset_mid;
        preload(12, 32'h0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 8'h30; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid mem_we in WRITE: got %b want 1", mem_we); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid async drop: got we=%b done=%b want 0/0", mem_we, done); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = 32'h0;
        #1;
        n_cmp += 3;
        if (mem[12] !== 32'h0) begin n_fail++; $display("FAIL rstmid mem: got %h want 00000000", mem[12]); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid req_ready: got %b want 1", req_ready); end
        if (done !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid done/rdata: got %b/%h want 0/0", done, rdata); end
        @(negedge clk);
    endtask

    task automatic test_misalign;
        logic        tw [3] = '{1'b1, 1'b0, 1'b0};
        logic [2:0]  tf [3] = '{3'd2, 3'd1, 3'd3};
        logic [7:0]  ta [3] = '{8'h41, 8'h13, 8'h44};
        res_t e, o;
        preload(16, 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            model(tw[i], tf[i], ta[i], 32'hC0FFEE11, e);
            run_req(tw[i], tf[i], ta[i], 32'hC0FFEE11, o);
            n_cmp += 5;
            if (o.lat !== e.lat) begin n_fail++; $display("FAIL mis[%0d] latency: got %0d want %0d", i, o.lat, e.lat); end
            if (o.err !== e.err) begin n_fail++; $display("FAIL mis[%0d] err: got %b want %b", i, o.err, e.err); end
            if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL mis[%0d] rdata: got %h want %h", i, o.rdata, e.rdata); end
            if (o.pulses !== e.pulses) begin n_fail++; $display("FAIL mis[%0d] pulses: got %0d want %0d", i, o.pulses, e.pulses); end
            if (o.memw !== e.memw) begin n_fail++; $display("FAIL mis[%0d] mem: got %h want %h", i, o.memw, e.memw); end
        end
    endtask

    task automatic test_random;
        logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] wd;
        res_t e, o;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 7)];
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            model(we, f3, a, wd, e);
            run_req(we, f3, a, wd, o);
            n_cmp += 5;
            if (o.lat !== e.lat) begin n_fail++; $display("FAIL rnd[%0d] latency we=%b f3=%0d a=%h: got %0d want %0d", i, we, f3, a, o.lat, e.lat); end
            if (o.err !== e.err) begin n_fail++; $display("FAIL rnd[%0d] err: got %b want %b", i, o.err, e.err); end
            if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL rnd[%0d] rdata we=%b f3=%0d a=%h: got %h want %h", i, we, f3, a, o.rdata, e.rdata); end
            if (o.pulses !== e.pulses) begin n_fail++; $display("FAIL rnd[%0d] pulses: got %0d want %0d", i, o.pulses, e.pulses); end
            if (o.memw !== e.memw) begin n_fail++; $display("FAIL rnd[%0d] mem we=%b f3=%0d a=%h: got %h want %h", i, we, f3, a, o.memw, e.memw); end
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 8'h0; req_wdata = 32'h0;
        ref_rdata = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        test_reset;
        test_loads;
        test_store_byte;
        test_back_to_back;
        test_reset_mid;
        test_misalign;
        test_random;
        @(negedge clk);
        n_cmp++;
        if (idle_viol !== 0) begin n_fail++; $display("FAIL mem_we in idle: got %0d cycles want 0", idle_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
